// File: rtl/tick_controller_pkg.sv
// tick_controller_pkg: shared state encoding and default sizing for the tick controller.
package tick_controller_pkg;
  localparam int CNT_W = 24;
  localparam int DEFAULT_PERIOD = 10000000;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: period counter that wraps to 0 after period-1 and flags the terminal count.
module tick_counter #(
  parameter int CNT_W = tick_controller_pkg::CNT_W
) (
  input  logic             Origin_Clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             terminal
);
  logic [CNT_W-1:0] r_count;
  assign terminal = r_count == period - CNT_W'(1);
  always_ff @(posedge Origin_Clock or posedge reset)
    if (reset) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (enable) r_count <= terminal ? '0 : r_count + CNT_W'(1);
endmodule

// File: rtl/tick_controller.sv
// tick_controller: configurable periodic/burst pulse generator with hold and stop.
module tick_controller #(
  parameter int CNT_W = tick_controller_pkg::CNT_W,
  parameter int DEFAULT_PERIOD = tick_controller_pkg::DEFAULT_PERIOD
) (
  input  logic             Origin_Clock,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [7:0]       cfg_burst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic             pulse,
  output logic             busy,
  output logic             done
);
  import tick_controller_pkg::*;
  state_t           r_state;
  logic [CNT_W-1:0] r_period;
  logic             r_oneshot;
  logic [7:0]       r_burst;
  logic [8:0]       r_remaining;
  logic             r_pulse, r_done;
  logic             w_term, w_active, w_fire, w_last, w_clear;
  logic [7:0]       w_burst;
  assign cfg_ready = r_state == S_IDLE;
  assign busy      = !cfg_ready;
  assign pulse     = r_pulse;
  assign done      = r_done;
  // A PAUSE cycle with hold released already counts, so the hold costs exactly its own length.
  assign w_active  = busy && !hold && !stop;
  assign w_fire    = w_active && w_term;
  assign w_last    = r_oneshot && r_remaining == 9'd1;
  assign w_clear   = !busy || stop;
  assign w_burst   = cfg_valid ? cfg_burst : r_burst;
  tick_counter #(.CNT_W(CNT_W)) u_cnt (
    .Origin_Clock(Origin_Clock),
    .reset       (reset),
    .clear       (w_clear),
    .enable      (w_active),
    .period      (r_period),
    .terminal    (w_term)
  );
  always_ff @(posedge Origin_Clock or posedge reset)
    if (reset) begin
      r_state     <= S_IDLE;
      r_period    <= CNT_W'(DEFAULT_PERIOD);
      r_oneshot   <= 1'b0;
      r_burst     <= 8'd1;
      r_remaining <= '0;
      r_pulse     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_pulse <= w_fire;
      r_done  <= w_fire && w_last;
      if (cfg_valid && cfg_ready) begin
        r_period  <= cfg_period < CNT_W'(2) ? CNT_W'(2) : cfg_period;
        r_oneshot <= cfg_oneshot;
        r_burst   <= cfg_burst;
      end
      if (!busy) begin
        if (start) begin
          r_state     <= S_RUN;
          r_remaining <= {w_burst == 8'd0, w_burst};
        end
      end else if (stop) r_state <= S_IDLE;
      else if (w_fire && w_last) r_state <= S_IDLE;
      else r_state <= hold ? S_PAUSE : S_RUN;
      if (w_fire && r_oneshot) r_remaining <= r_remaining - 9'd1;
    end
endmodule

// File: tb/tb_tick_controller.sv
// tb_tick_controller: directed sequences for the tick controller with immediate-assertion checks.
module tb_tick_controller;
  localparam int CNT_W = 24;
  localparam int DEF_P = 20;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_valid = 1'b0, cfg_oneshot = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [7:0]       cfg_burst = '0;
  logic             cfg_ready, pulse, busy, done;
  int               n_cmp = 0, n_err = 0;
  int               q[$];
  int               done_k, n_done, busy_lo;
  always #5 clk = ~clk;
  tick_controller #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_P)) dut (
    .Origin_Clock(clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .cfg_burst   (cfg_burst),
    .start       (start),
    .stop        (stop),
    .hold        (hold),
    .pulse       (pulse),
    .busy        (busy),
    .done        (done)
  );
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int at(int i);
    return q.size() > i ? q[i] : -1;
  endfunction
  task automatic observe(int a, int b);
    q.delete();
    done_k = -1;
    n_done = 0;
    busy_lo = -1;
    for (int k = a; k <= b; k++) begin
      tick();
      if (pulse) q.push_back(k);
      if (done) begin
        n_done++;
        done_k = k;
      end
      if (!busy && busy_lo < 0) busy_lo = k;
    end
  endtask
  task automatic configure(int per, bit os, int bur, bit st);
    cfg_valid = 1'b1;
    cfg_period = CNT_W'(per);
    cfg_oneshot = os;
    cfg_burst = 8'(bur);
    start = st;
    tick();
    cfg_valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    check("rst_pulse", pulse, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_count", dut.u_cnt.r_count, 0);
    check("rst_period", dut.r_period, DEF_P);
    @(negedge clk) reset = 1'b0;
    // default configuration, continuous
    do_start();
    check("def_busy", busy, 1);
    observe(1, 41);
    check("def_p1", at(0), DEF_P);
    check("def_p2", at(1), 2 * DEF_P);
    check("def_npulse", q.size(), 2);
    check("def_ndone", n_done, 0);
    check("def_busy_hi", busy_lo, -1);
    do_stop();
    // burst of 3 at period 5
    configure(5, 1, 3, 0);
    do_start();
    observe(1, 20);
    check("bur_p1", at(0), 5);
    check("bur_p2", at(1), 10);
    check("bur_p3", at(2), 15);
    check("bur_npulse", q.size(), 3);
    check("bur_done_k", done_k, 15);
    check("bur_ndone", n_done, 1);
    check("bur_busy_lo", busy_lo, 15);
    check("bur_ready", cfg_ready, 1);
    // hold for 3 cycles at period 4, configured on the start edge
    configure(4, 0, 0, 1);
    tick();
    check("hold_e1_pulse", pulse, 0);
    hold = 1'b1;
    tick();
    tick();
    tick();
    check("hold_busy", busy, 1);
    check("hold_frozen", dut.u_cnt.r_count, 1);
    check("hold_nopulse", pulse, 0);
    hold = 1'b0;
    observe(5, 12);
    check("hold_p1", at(0), 7);
    check("hold_p2", at(1), 11);
    check("hold_busy_hi", busy_lo, -1);
    do_stop();
    // stop on the terminal-count edge at period 6
    configure(6, 0, 0, 1);
    observe(1, 5);
    check("stop_pre_npulse", q.size(), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_pulse", pulse, 0);
    check("stop_busy", busy, 0);
    check("stop_count", dut.u_cnt.r_count, 0);
    check("stop_done", done, 0);
    do_start();
    observe(1, 8);
    check("stop_restart_p1", at(0), 6);
    do_stop();
    // period clamp to 2 and configuration refused while busy
    configure(1, 0, 0, 1);
    check("clamp_period", dut.r_period, 2);
    observe(1, 6);
    check("clamp_p1", at(0), 2);
    check("clamp_p3", at(2), 6);
    cfg_valid = 1'b1;
    cfg_period = CNT_W'(9);
    #1;
    check("busy_ready", cfg_ready, 0);
    tick();
    cfg_valid = 1'b0;
    check("busy_period", dut.r_period, 2);
    observe(8, 12);
    check("busy_p1", at(0), 8);
    check("busy_p3", at(2), 12);
    do_stop();
    // asynchronous reset mid-burst
    configure(3, 1, 5, 1);
    observe(1, 6);
    check("ar_p2", at(1), 6);
    check("ar_pulse_hi", pulse, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_pulse", pulse, 0);
    check("ar_done", done, 0);
    check("ar_busy", busy, 0);
    check("ar_ready", cfg_ready, 1);
    check("ar_count", dut.u_cnt.r_count, 0);
    check("ar_remaining", dut.r_remaining, 0);
    check("ar_period", dut.r_period, DEF_P);
    @(negedge clk) reset = 1'b0;
    tick();
    check("ar_idle", busy, 0);
    do_start();
    observe(1, 41);
    check("ar_run_p1", at(0), DEF_P);
    check("ar_run_p2", at(1), 2 * DEF_P);
    check("ar_run_ndone", n_done, 0);
    do_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tick_controller.md
TICK_CONTROLLER -- requirements
Module: tick_controller

Interface
REQ-001 Parameter: CNT_W, 24, width of period counter and period register.
REQ-002 Parameter: DEFAULT_PERIOD, 10000000, period loaded at reset.
REQ-003 Origin_Clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_valid  in  1  configuration offer.
REQ-006 cfg_ready  out  1  configuration accepted when high with cfg_valid.
REQ-007 cfg_period  in  CNT_W  pulse period in cycles.
REQ-008 cfg_oneshot  in  1  0 = continuous, 1 = burst mode.
REQ-009 cfg_burst  in  8  number of pulses in burst mode; 0 means 256.
REQ-010 start  in  1  begin pulse generation.
REQ-011 stop  in  1  abort generation.
REQ-012 hold  in  1  freeze counter while high.
REQ-013 pulse  out  1  registered single-cycle tick.
REQ-014 busy  out  1  high in RUN or PAUSE.
REQ-015 done  out  1  single-cycle burst-complete flag.

Function
REQ-016 States: IDLE, RUN, PAUSE; busy SHALL equal (state != IDLE).
REQ-017 cfg_ready SHALL be high only in IDLE; cfg_valid && cfg_ready latches period, mode and burst at that edge; cfg_valid outside IDLE is ignored.
REQ-018 A latched cfg_period below 2 SHALL be stored as 2.
REQ-019 IDLE + start -> RUN; count <= 0; remaining <= burst (0 -> 256); start with cfg_valid at the same edge uses the new configuration.
REQ-020 In RUN, count increments each cycle and wraps to 0 after reaching period-1.
REQ-021 pulse <= 1 at the edge where state is RUN, count == period-1 and stop is low; otherwise pulse <= 0. The first pulse is high exactly period cycles after the start edge, and later pulses follow every period cycles.
REQ-022 In burst mode, each pulse decrements remaining. The edge that issues the final pulse SHALL also set done <= 1 for one cycle and state <= IDLE.
REQ-023 In continuous mode, done SHALL never assert.
REQ-024 In RUN, hold high -> PAUSE with count frozen and no pulse. In PAUSE, hold low -> RUN, and counting resumes from the frozen value.
REQ-025 hold high at a terminal-count edge: PAUSE wins, and the pulse is deferred until count reaches period-1 after resume.
REQ-026 stop in RUN or PAUSE -> IDLE next edge with count <= 0; stop overrides hold and terminal count (no pulse, no done).
REQ-027 start while busy SHALL be ignored.
REQ-028 Counter and period arithmetic is unsigned CNT_W bits; the remaining counter is 9 bits.

Reset
REQ-029 Asserting reset SHALL immediately force: state IDLE, count 0, remaining 0, pulse 0, done 0, busy 0, cfg_ready 1.
REQ-030 Reset SHALL restore period to DEFAULT_PERIOD, mode to continuous and burst to 1.
REQ-031 Reset asserted mid-RUN SHALL abort with no further pulse or done; after release, the block waits in IDLE for start.

Structure
REQ-032 A shared package SHALL hold the state enumeration, CNT_W and DEFAULT_PERIOD.
REQ-033 One sub-module, tick_counter, SHALL own the count register with the inputs clear, enable and period and the output terminal (count == period-1).
REQ-034 tick_controller SHALL contain the FSM, configuration registers, burst counter and the pulse/done registers.

Verification
REQ-035 Sequence: reset, then start, with no configuration -> first pulse at cycle 10000000 after start, second at 20000000, and done never asserts.
REQ-036 Sequence: configure period=5, oneshot=1, burst=3, then start at edge 0 -> pulses at cycles 5, 10 and 15; done high in cycle 15; busy low from cycle 15; cfg_ready high again.
REQ-037 Sequence: period=4, continuous; hold for 3 cycles starting 2 cycles after start -> first pulse delayed to cycle 7, and busy stays high throughout.
REQ-038 Sequence: period=6, continuous; stop asserted on the terminal-count edge -> no pulse, state IDLE, count 0; a later start gives its first pulse 6 cycles later.
REQ-039 Sequence: cfg_period=1 -> stored as 2, so pulses appear every 2 cycles; cfg_valid offered while busy -> cfg_ready 0, and the period is unchanged.
REQ-040 Sequence: reset asserted asynchronously mid-burst (period=3, burst=5) after 2 pulses -> pulse, done and busy go low immediately; after release, period reads back as DEFAULT_PERIOD on the next run.
